// File: rtl/simple_demux.sv
// One-input, two-output stream demultiplexer with a small FIFO per output.
// sel routes each accepted word to A (0) or B (1); per-output acceptance counters wrap at 16 bits.

module simple_demux_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              do_push_s;
    logic              do_pop_s;

    // The extra pointer MSB separates full from empty when the index bits match.
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign rdata     = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Next-state pointers and storage write.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers; reset empties the FIFO and overrides any push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {(AW + 1){1'b0}};
            rd_ptr_q <= {(AW + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: data is only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

`ifdef FORMAL
module simple_demux_formal_env (
    input logic sel
);
    // Constrain the route to A so B-side state can be proven constant.
    always_comb begin
        assume (sel == 1'b0);
    end
endmodule
`endif

module simple_demux #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              sel,
    output logic              out_a_valid,
    input  logic              out_a_ready,
    output logic [DATA_W-1:0] out_a_data,
    output logic              out_b_valid,
    input  logic              out_b_ready,
    output logic [DATA_W-1:0] out_b_data,
    output logic [15:0]       count_a,
    output logic [15:0]       count_b
);
    logic        full_a_s, empty_a_s;
    logic        full_b_s, empty_b_s;
    logic        push_a_s, push_b_s;
    logic        pop_a_s,  pop_b_s;
    logic [15:0] count_a_q, count_a_d;
    logic [15:0] count_b_q, count_b_d;

    // Readiness looks only at the currently selected FIFO, never at in_valid,
    // and ignores a same-cycle pop so a full FIFO never passes data through.
    assign in_ready = sel ? !full_b_s : !full_a_s;
    assign push_a_s = in_valid && in_ready && (sel == 1'b0);
    assign push_b_s = in_valid && in_ready && (sel == 1'b1);
    assign pop_a_s  = out_a_valid && out_a_ready;
    assign pop_b_s  = out_b_valid && out_b_ready;

    assign out_a_valid = !empty_a_s;
    assign out_b_valid = !empty_b_s;
    assign count_a     = count_a_q;
    assign count_b     = count_b_q;

    simple_demux_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .push  (push_a_s),
        .pop   (pop_a_s),
        .wdata (in_data),
        .full  (full_a_s),
        .empty (empty_a_s),
        .rdata (out_a_data)
    );

    simple_demux_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .push  (push_b_s),
        .pop   (pop_b_s),
        .wdata (in_data),
        .full  (full_b_s),
        .empty (empty_b_s),
        .rdata (out_b_data)
    );

    // Acceptance counters, wrapping naturally at 16 bits.
    always_comb begin
        count_a_d = count_a_q;
        count_b_d = count_b_q;
        if (push_a_s) begin
            count_a_d = count_a_q + 16'd1;
        end else begin
            count_a_d = count_a_q;
        end
        if (push_b_s) begin
            count_b_d = count_b_q + 16'd1;
        end else begin
            count_b_d = count_b_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_a_q <= 16'd0;
            count_b_q <= 16'd0;
        end else begin
            count_a_q <= count_a_d;
            count_b_q <= count_b_d;
        end
    end

`ifdef FORMAL
    simple_demux_formal_env u_formal_env (
        .sel (sel)
    );
`endif
endmodule

// File: tb/tb_simple_demux.sv
// Bench for simple_demux: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.

module tb_simple_demux;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              sel;
    logic              out_a_valid;
    logic              out_a_ready;
    logic [DATA_W-1:0] out_a_data;
    logic              out_b_valid;
    logic              out_b_ready;
    logic [DATA_W-1:0] out_b_data;
    logic [15:0]       count_a;
    logic [15:0]       count_b;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [DATA_W-1:0] qa[$];
    logic [DATA_W-1:0] qb[$];
    logic [15:0]       m_cnt_a = 16'd0;
    logic [15:0]       m_cnt_b = 16'd0;

    simple_demux #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .sel         (sel),
        .out_a_valid (out_a_valid),
        .out_a_ready (out_a_ready),
        .out_a_data  (out_a_data),
        .out_b_valid (out_b_valid),
        .out_b_ready (out_b_ready),
        .out_b_data  (out_b_data),
        .count_a     (count_a),
        .count_b     (count_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word is accepted when the selected queue holds fewer
    // than DEPTH words before this edge's pop; reset clears everything.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                qa.delete();
                qb.delete();
                m_cnt_a = 16'd0;
                m_cnt_b = 16'd0;
            end else begin
                bit acc_a, acc_b;
                acc_a = in_valid && !sel && (qa.size() < DEPTH);
                acc_b = in_valid &&  sel && (qb.size() < DEPTH);
                if (qa.size() > 0 && out_a_ready) void'(qa.pop_front());
                if (qb.size() > 0 && out_b_ready) void'(qb.pop_front());
                if (acc_a) begin
                    qa.push_back(in_data);
                    m_cnt_a = m_cnt_a + 16'd1;
                end
                if (acc_b) begin
                    qb.push_back(in_data);
                    m_cnt_b = m_cnt_b + 16'd1;
                end
            end
        end
    end

    // Cycle compare against the model on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_a_valid", {31'd0, out_a_valid}, {31'd0, qa.size() > 0});
            check("m_b_valid", {31'd0, out_b_valid}, {31'd0, qb.size() > 0});
            if (qa.size() > 0) check("m_a_data", out_a_data, qa[0]);
            if (qb.size() > 0) check("m_b_data", out_b_data, qb[0]);
            check("m_in_ready", {31'd0, in_ready},
                  {31'd0, sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH)});
            check("m_count_a", {16'd0, count_a}, {16'd0, m_cnt_a});
            check("m_count_b", {16'd0, count_b}, {16'd0, m_cnt_b});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; sel = 1'b0;
        out_a_ready = 1'b0; out_b_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        check("rst_a_valid", {31'd0, out_a_valid}, 32'd0);
        check("rst_b_valid", {31'd0, out_b_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_count_a", {16'd0, count_a}, 32'd0);
        check("rst_count_b", {16'd0, count_b}, 32'd0);

        // Single word to A with one-cycle latency.
        in_valid = 1'b1; sel = 1'b0; in_data = 32'h1111_1111; out_a_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_a_valid", {31'd0, out_a_valid}, 32'd1);
        check("lat_a_data", out_a_data, 32'h1111_1111);
        check("lat_count_a", {16'd0, count_a}, 32'd1);
        check("lat_b_valid", {31'd0, out_b_valid}, 32'd0);
        tick();

        // Backpressure on A: two accepts, third word stalls until drained.
        out_a_ready = 1'b0; in_valid = 1'b1; sel = 1'b0;
        in_data = 32'hA000_0001; tick();
        in_data = 32'hA000_0002; tick();
        in_data = 32'hA000_0003;
        check("bp_full_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("bp_stall_ready", {31'd0, in_ready}, 32'd0);
        check("bp_stall_count", {16'd0, count_a}, 32'd3);
        check("bp_head", out_a_data, 32'hA000_0001);
        out_a_ready = 1'b1;
        tick();
        check("bp_drain1", out_a_data, 32'hA000_0002);
        tick();
        in_valid = 1'b0;
        check("bp_third", out_a_data, 32'hA000_0003);
        check("bp_count", {16'd0, count_a}, 32'd4);
        tick();

        // A full, switch sel to B while in_valid held.
        out_a_ready = 1'b0; out_b_ready = 1'b0; in_valid = 1'b1; sel = 1'b0;
        in_data = 32'hB000_0001; tick();
        in_data = 32'hB000_0002; tick();
        in_data = 32'hC000_0001;
        #1;
        check("sw_ready_a", {31'd0, in_ready}, 32'd0);
        sel = 1'b1;
        #1;
        check("sw_ready_b", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("sw_b_valid", {31'd0, out_b_valid}, 32'd1);
        check("sw_b_data", out_b_data, 32'hC000_0001);
        check("sw_count_b", {16'd0, count_b}, 32'd1);
        check("sw_count_a", {16'd0, count_a}, 32'd6);
        check("sw_a_head", out_a_data, 32'hB000_0001);
        out_a_ready = 1'b1; out_b_ready = 1'b1;
        tick(); tick(); tick();

        // One entry, simultaneous push/pop across pointer wrap.
        out_a_ready = 1'b0; in_valid = 1'b1; sel = 1'b0; in_data = 32'hD000_0000;
        tick();
        out_a_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_data = 32'hD000_0000 + 32'(i);
            tick();
            check("pp_valid", {31'd0, out_a_valid}, 32'd1);
            check("pp_data", out_a_data, 32'hD000_0000 + 32'(i));
        end
        in_valid = 1'b0;
        tick();
        check("pp_empty", {31'd0, out_a_valid}, 32'd0);
        check("pp_count", {16'd0, count_a}, 32'd17);

        // Mixed directed pattern, checked by the model.
        for (int i = 0; i < 40; i++) begin
            in_valid    = (i % 3) != 2;
            sel         = i[1] ^ i[3];
            in_data     = 32'hE000_0000 + 32'(i);
            out_a_ready = (i % 4) != 0;
            out_b_ready = (i % 5) < 3;
            tick();
        end

        // Reset mid-operation discards B contents; a push in the reset cycle is ignored.
        in_valid = 1'b1; sel = 1'b1; out_b_ready = 1'b0; out_a_ready = 1'b0;
        in_data = 32'hF000_0001; tick();
        in_data = 32'hF000_0002; tick();
        check("pre_rst_b_valid", {31'd0, out_b_valid}, 32'd1);
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_b_valid", {31'd0, out_b_valid}, 32'd0);
        check("post_rst_count_b", {16'd0, count_b}, 32'd0);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_count_a", {16'd0, count_a}, 32'd0);

        // Counter wrap: 65535 accepts, then one more.
        in_valid = 1'b1; sel = 1'b0; out_a_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_data = 32'(i);
            tick();
        end
        check("wrap_ffff", {16'd0, count_a}, 32'h0000_FFFF);
        in_data = 32'h0001_0000;
        tick();
        check("wrap_zero", {16'd0, count_a}, 32'd0);
        check("wrap_data", out_a_data, 32'h0001_0000);
        in_valid = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/simple_demux.md
SIMPLE_DEMUX -- requirements
Module: simple_demux

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 32, meaning payload width in bits.
REQ-002 The block SHALL expose parameter DEPTH, default 2, meaning entries per output FIFO (power of two, >= 2).
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port in_valid  input  1  upstream word present.
REQ-006 Port in_ready  output  1  block can accept the upstream word this cycle.
REQ-007 Port in_data  input  DATA_W  upstream payload.
REQ-008 Port sel  input  1  route select, sampled with the word: 0 -> output A, 1 -> output B.
REQ-009 Port out_a_valid  output  1  output A word present.
REQ-010 Port out_a_ready  input  1  output A consumer accepts.
REQ-011 Port out_a_data  output  DATA_W  output A payload.
REQ-012 Port out_b_valid / out_b_ready / out_b_data  output / input / output  1 / 1 / DATA_W  same roles as for A, for output B.
REQ-013 Port count_a  output  16  words accepted toward A since reset.
REQ-014 Port count_b  output  16  words accepted toward B since reset.

Function
REQ-015 Input transfer SHALL occur when in_valid && in_ready are both high at a rising edge.
REQ-016 in_ready SHALL be combinational: high iff the FIFO selected by the current sel is not full; it SHALL NOT depend on in_valid.
REQ-017 An accepted word SHALL be written to FIFO A if sel=0, else FIFO B; the other FIFO SHALL be unchanged.
REQ-018 Each FIFO SHALL hold DEPTH entries, with read/write pointers one bit wider than log2(DEPTH); full = MSBs differ and low bits equal, empty = pointers equal.
REQ-019 Pointers SHALL wrap modulo 2*DEPTH with no lost or duplicated entries.
REQ-020 out_x_valid SHALL be high iff FIFO x is non-empty; out_x_data SHALL be the head entry, held stable while out_x_valid && !out_x_ready.
REQ-021 Output pop SHALL occur when out_x_valid && out_x_ready are both high at a rising edge.
REQ-022 Latency SHALL be exactly 1 cycle: a word accepted at edge N SHALL appear at the output from edge N, visible in cycle N+1, if its FIFO was empty.
REQ-023 Simultaneous push and pop on the same FIFO SHALL both take effect; occupancy is unchanged.
REQ-024 A full FIFO SHALL deassert in_ready for that select even if a pop occurs in the same cycle (no same-cycle pass-through).
REQ-025 Per-output ordering SHALL be FIFO; no ordering is guaranteed between A and B.
REQ-026 A change of sel while in_valid is high and in_ready is low SHALL be allowed; in_ready SHALL re-evaluate against the newly selected FIFO.
REQ-027 count_a and count_b SHALL each increment by 1 per accepted word for their output and wrap from 16'hFFFF to 16'h0000.
REQ-028 Under the FORMAL define, the block SHALL contain a combinational assumption sel == 1'b0. Under that constraint, scorr SHALL reduce FIFO B, count_b and out_b_valid to constant 0.

Reset
REQ-029 While rst is high at a rising edge, both FIFOs SHALL become empty (pointers 0) and count_a/count_b SHALL be set to 0.
REQ-030 After reset, out_a_valid = out_b_valid = 0 and in_ready = 1.
REQ-031 Reset asserted mid-operation SHALL discard all buffered words. No pop or push SHALL take effect in a reset cycle.
REQ-032 FIFO storage contents SHALL NOT require reset. out_x_data is don't-care while out_x_valid = 0.

Verification
REQ-033 Reset, then push 0x11111111 with sel=0 while out_a_ready=1 -> out_a_valid=1 with data 0x11111111 next cycle, count_a=1, out_b_valid stays 0.
REQ-034 Hold out_a_ready=0 and push three words with sel=0 at DEPTH=2 -> in_ready drops after 2 accepts, third word stalls. Raising out_a_ready drains 2 words in order, then the third is accepted.
REQ-035 FIFO A full, out_b_ready=0, switch sel to 1 with in_valid held -> in_ready rises, and the word lands in B only.
REQ-036 FIFO holding one entry, push and pop in the same cycle -> occupancy stays 1 and order is preserved over 10 such cycles spanning pointer wrap.
REQ-037 Push 2 words to B with out_b_ready=0, assert rst for 1 cycle -> out_b_valid=0, count_b=0, in_ready=1 in the cycle after reset.
REQ-038 Preload count_a to 16'hFFFF via 65535 accepts, then one more accept -> count_a=16'h0000.
